rename_unit: RTL and testbench

- Parametrised register-rename stage between decode and dispatch.
- Maps WIDTH architectural-register instructions per cycle to physical registers using a speculative RAT and a free-list bitmap.
- Frees old destination pregs on retire and keeps a committed RAT so that a flush can restore precise state in one cycle.
- Adds backpressure, intra-group dependency forwarding and free-list stall.

---
 rtl/rename_unit.sv | 201 ++++++++++++++++++++
 tb/tb_rename_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// Register-rename stage: speculative + committed RATs, free-list bitmap, one-cycle flush restore.
// Optional RENAME_FREE_COUNT_EN adds a registered o_free_count output.
module rename_unit #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned NUM_AREG   = 32,
  parameter int unsigned NUM_PREG   = 128,
  parameter int unsigned NUM_RETIRE = 3,
  parameter int unsigned PAYLOAD_W  = 48,
  localparam int unsigned AW = $clog2(NUM_AREG),
  localparam int unsigned PW = $clog2(NUM_PREG)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_slot_valid,
  input  logic [WIDTH*AW-1:0]        i_src0_areg,
  input  logic [WIDTH*AW-1:0]        i_src1_areg,
  input  logic [WIDTH*AW-1:0]        i_dst_areg,
  input  logic [WIDTH*PAYLOAD_W-1:0] i_payload,
  output logic                       o_valid,
  input  logic                       i_out_ready,
  output logic [WIDTH-1:0]           o_slot_valid,
  output logic [WIDTH*PW-1:0]        o_src0_preg,
  output logic [WIDTH*PW-1:0]        o_src1_preg,
  output logic [WIDTH*PW-1:0]        o_dst_preg,
  output logic [WIDTH*PW-1:0]        o_old_dst_preg,
  output logic [WIDTH*PAYLOAD_W-1:0] o_payload,
  input  logic [NUM_RETIRE-1:0]      i_retire_valid,
  input  logic [NUM_RETIRE*AW-1:0]   i_retire_dst_areg,
  input  logic [NUM_RETIRE*PW-1:0]   i_retire_dst_preg,
  input  logic [NUM_RETIRE*PW-1:0]   i_retire_old_preg,
`ifdef RENAME_FREE_COUNT_EN
  output logic [PW:0]                o_free_count,
`endif
  input  logic                       i_flush
);

  logic [PW-1:0]              r_spec_rat [NUM_AREG];
  logic [PW-1:0]              r_com_rat  [NUM_AREG];
  logic [NUM_PREG-1:0]        r_free;
  logic                       r_valid;
  logic [WIDTH-1:0]           r_slot_valid;
  logic [WIDTH*PW-1:0]        r_src0, r_src1, r_dst, r_old;
  logic [WIDTH*PAYLOAD_W-1:0] r_payload;

  logic [WIDTH-1:0]           w_need;
  logic [PW:0]                w_need_cnt, w_free_cnt;
  logic                       w_ready, w_accept;
  logic [PW-1:0]              w_alloc [WIDTH];
  logic [NUM_PREG-1:0]        w_alloc_mask;
  logic [WIDTH*PW-1:0]        w_src0, w_src1, w_dst, w_old;
  logic [PW-1:0]              w_spec_next [NUM_AREG];
  logic [PW-1:0]              w_com_next  [NUM_AREG];
  logic [NUM_PREG-1:0]        w_free_next;

  function automatic logic [PW:0] popcnt(input logic [NUM_PREG-1:0] v);
    logic [PW:0] c;
    c = '0;
    for (int p = 0; p < NUM_PREG; p++) c = c + (PW+1)'(v[p]);
    return c;
  endfunction

  always_comb begin
    w_need     = '0;
    w_need_cnt = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_need[k]  = i_slot_valid[k] & (i_dst_areg[k*AW +: AW] != '0);
      w_need_cnt = w_need_cnt + (PW+1)'(w_need[k]);
    end
    w_free_cnt = popcnt(r_free);
    w_ready    = (!r_valid | i_out_ready) & !i_flush & (w_free_cnt >= w_need_cnt);
    w_accept   = i_valid & w_ready;
  end

  // Each needing slot takes the lowest free preg not already claimed by an earlier slot.
  always_comb begin
    logic [NUM_PREG-1:0] avail;
    avail        = r_free;
    avail[0]     = 1'b0;
    w_alloc_mask = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_alloc[k] = '0;
      for (int p = NUM_PREG - 1; p >= 1; p--) begin
        if (avail[p]) w_alloc[k] = PW'(p);
      end
      if (w_need[k]) begin
        avail[w_alloc[k]]        = 1'b0;
        w_alloc_mask[w_alloc[k]] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [AW-1:0] a0, a1, ad;
    logic [PW-1:0] p0, p1, po;
    w_src0 = '0;
    w_src1 = '0;
    w_dst  = '0;
    w_old  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      a0 = i_src0_areg[k*AW +: AW];
      a1 = i_src1_areg[k*AW +: AW];
      ad = i_dst_areg[k*AW +: AW];
      p0 = r_spec_rat[a0];
      p1 = r_spec_rat[a1];
      po = r_spec_rat[ad];
      // Later earlier-slots overwrite, so the newest earlier writer wins.
      for (int j = 0; j < WIDTH; j++) begin
        if (j < k && w_need[j]) begin
          if (i_dst_areg[j*AW +: AW] == a0) p0 = w_alloc[j];
          if (i_dst_areg[j*AW +: AW] == a1) p1 = w_alloc[j];
          if (i_dst_areg[j*AW +: AW] == ad) po = w_alloc[j];
        end
      end
      w_src0[k*PW +: PW] = (a0 == '0) ? '0 : p0;
      w_src1[k*PW +: PW] = (a1 == '0) ? '0 : p1;
      w_dst[k*PW +: PW]  = w_need[k] ? w_alloc[k] : '0;
      w_old[k*PW +: PW]  = w_need[k] ? po : '0;
    end
  end

  always_comb begin
    w_com_next = r_com_rat;
    for (int r = 0; r < NUM_RETIRE; r++) begin
      if (i_retire_valid[r] && i_retire_dst_areg[r*AW +: AW] != '0)
        w_com_next[i_retire_dst_areg[r*AW +: AW]] = i_retire_dst_preg[r*PW +: PW];
    end
    w_free_next = r_free;
    if (w_accept) w_free_next = w_free_next & ~w_alloc_mask;
    for (int r = 0; r < NUM_RETIRE; r++) begin
      if (i_retire_valid[r] && i_retire_old_preg[r*PW +: PW] != '0)
        w_free_next[i_retire_old_preg[r*PW +: PW]] = 1'b1;
    end
    w_spec_next = r_spec_rat;
    if (i_flush) begin
      // Free list rebuilt from the post-retire committed map.
      w_free_next = '1;
      for (int a = 0; a < NUM_AREG; a++) w_free_next[w_com_next[a]] = 1'b0;
      w_free_next[0] = 1'b0;
      w_spec_next    = w_com_next;
    end else if (w_accept) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (w_need[k]) w_spec_next[i_dst_areg[k*AW +: AW]] = w_alloc[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int a = 0; a < NUM_AREG; a++) begin
        r_spec_rat[a] <= PW'(a);
        r_com_rat[a]  <= PW'(a);
      end
      for (int p = 0; p < NUM_PREG; p++) r_free[p] <= (p >= NUM_AREG);
      r_valid      <= 1'b0;
      r_slot_valid <= '0;
      r_src0       <= '0;
      r_src1       <= '0;
      r_dst        <= '0;
      r_old        <= '0;
      r_payload    <= '0;
    end else begin
      r_spec_rat <= w_spec_next;
      r_com_rat  <= w_com_next;
      r_free     <= w_free_next;
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid      <= 1'b1;
        r_slot_valid <= i_slot_valid;
        r_src0       <= w_src0;
        r_src1       <= w_src1;
        r_dst        <= w_dst;
        r_old        <= w_old;
        r_payload    <= i_payload;
      end else if (i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef RENAME_FREE_COUNT_EN
  logic [PW:0] r_free_count;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_free_count <= (PW+1)'(NUM_PREG - NUM_AREG);
    else          r_free_count <= popcnt(w_free_next);
  end
  assign o_free_count = r_free_count;
`endif

  assign o_ready        = w_ready;
  assign o_valid        = r_valid;
  assign o_slot_valid   = r_slot_valid;
  assign o_src0_preg    = r_src0;
  assign o_src1_preg    = r_src1;
  assign o_dst_preg     = r_dst;
  assign o_old_dst_preg = r_old;
  assign o_payload      = r_payload;

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: vector table of rename groups plus stall, backpressure,
// flush and retire-ordering sequences.
module tb_rename_unit;
  localparam int W = 2, AW = 5, PW = 7, PL = 48, NR = 3;

  logic i_clk = 1'b0, i_rst_n, i_valid, o_ready, o_valid, i_out_ready, i_flush;
  logic [W-1:0]       i_slot_valid, o_slot_valid;
  logic [W*AW-1:0]    i_src0_areg, i_src1_areg, i_dst_areg;
  logic [W*PL-1:0]    i_payload, o_payload;
  logic [W*PW-1:0]    o_src0_preg, o_src1_preg, o_dst_preg, o_old_dst_preg;
  logic [NR-1:0]      i_retire_valid;
  logic [NR*AW-1:0]   i_retire_dst_areg;
  logic [NR*PW-1:0]   i_retire_dst_preg, i_retire_old_preg;
`ifdef RENAME_FREE_COUNT_EN
  logic [PW:0]        o_free_count;
`endif

  rename_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_slot_valid(i_slot_valid), .i_src0_areg(i_src0_areg), .i_src1_areg(i_src1_areg),
    .i_dst_areg(i_dst_areg), .i_payload(i_payload), .o_valid(o_valid),
    .i_out_ready(i_out_ready), .o_slot_valid(o_slot_valid), .o_src0_preg(o_src0_preg),
    .o_src1_preg(o_src1_preg), .o_dst_preg(o_dst_preg), .o_old_dst_preg(o_old_dst_preg),
    .o_payload(o_payload), .i_retire_valid(i_retire_valid),
    .i_retire_dst_areg(i_retire_dst_areg), .i_retire_dst_preg(i_retire_dst_preg),
    .i_retire_old_preg(i_retire_old_preg),
`ifdef RENAME_FREE_COUNT_EN
    .o_free_count(o_free_count),
`endif
    .i_flush(i_flush)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  sv;
    logic [9:0]  d, a, b;
    logic [13:0] e_d, e_o, e_s0, e_s1;
  } vec_t;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] sv,
                              input int d0, input int a0, input int b0,
                              input int d1, input int a1, input int b1,
                              input int ed0, input int eo0, input int es00, input int es10,
                              input int ed1, input int eo1, input int es01, input int es11);
    vec_t v;
    v.sv   = sv;
    v.d    = {5'(d1), 5'(d0)};
    v.a    = {5'(a1), 5'(a0)};
    v.b    = {5'(b1), 5'(b0)};
    v.e_d  = {7'(ed1), 7'(ed0)};
    v.e_o  = {7'(eo1), 7'(eo0)};
    v.e_s0 = {7'(es01), 7'(es00)};
    v.e_s1 = {7'(es11), 7'(es10)};
    return v;
  endfunction

  task automatic set_grp(input logic [1:0] sv, input int d0, input int a0, input int b0,
                         input int d1, input int a1, input int b1);
    i_slot_valid = sv;
    i_dst_areg   = {5'(d1), 5'(d0)};
    i_src0_areg  = {5'(a1), 5'(a0)};
    i_src1_areg  = {5'(b1), 5'(b0)};
  endtask

  task automatic retire(input logic [2:0] v, input int ar2, input int dp2, input int op2,
                        input int ar0, input int dp0, input int op0);
    i_retire_valid    = v;
    i_retire_dst_areg = {5'(ar2), 5'd0, 5'(ar0)};
    i_retire_dst_preg = {7'(dp2), 7'd0, 7'(dp0)};
    i_retire_old_preg = {7'(op2), 7'd0, 7'(op0)};
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [W*PL-1:0] pl;
    pl = {48'(idx * 7 + 1), 48'(idx * 13 + 5)};
    @(negedge i_clk);
    i_slot_valid = v.sv; i_dst_areg = v.d; i_src0_areg = v.a; i_src1_areg = v.b;
    i_payload = pl; i_valid = 1'b1;
    #1;
    chk($sformatf("v%0d_ready", idx), 128'(o_ready), 128'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk($sformatf("v%0d_valid", idx), 128'(o_valid), 128'd1);
    chk($sformatf("v%0d_slot_valid", idx), 128'(o_slot_valid), 128'(v.sv));
    chk($sformatf("v%0d_dst", idx), 128'(o_dst_preg), 128'(v.e_d));
    chk($sformatf("v%0d_old", idx), 128'(o_old_dst_preg), 128'(v.e_o));
    chk($sformatf("v%0d_payload", idx), 128'(o_payload), 128'(pl));
    for (int k = 0; k < W; k++) begin
      if (v.sv[k]) begin
        chk($sformatf("v%0d_s%0d_src0", idx, k), 128'(o_src0_preg[k*PW +: PW]),
            128'(v.e_s0[k*PW +: PW]));
        chk($sformatf("v%0d_s%0d_src1", idx, k), 128'(o_src1_preg[k*PW +: PW]),
            128'(v.e_s1[k*PW +: PW]));
      end
    end
  endtask

  vec_t vecs [5];
  int   miss;

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_out_ready = 1'b1; i_flush = 1'b0;
    i_payload = '0;
    set_grp(2'b00, 0, 0, 0, 0, 0, 0);
    retire(3'b000, 0, 0, 0, 0, 0, 0);

    vecs[0] = mk(2'b11, 1, 2, 3, 4, 1, 1,  32, 1, 2, 3,    33, 4, 32, 32);
    vecs[1] = mk(2'b11, 0, 1, 4, 5, 0, 1,  0, 0, 32, 33,   34, 5, 0, 32);
    vecs[2] = mk(2'b11, 1, 1, 5, 1, 1, 6,  35, 32, 32, 34, 36, 35, 35, 6);
    vecs[3] = mk(2'b01, 7, 1, 7, 8, 1, 1,  37, 7, 36, 7,   0, 0, 0, 0);
    vecs[4] = mk(2'b11, 2, 7, 2, 3, 2, 3,  38, 2, 37, 2,   39, 3, 38, 3);

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 128'(o_valid), 128'd0);
    chk("rst_dst", 128'(o_dst_preg), 128'd0);
    chk("rst_old", 128'(o_old_dst_preg), 128'd0);
    chk("rst_payload", 128'(o_payload), 128'd0);
`ifdef RENAME_FREE_COUNT_EN
    chk("rst_free_count", 128'(o_free_count), 128'd96);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply(vecs[i], i);

    // Backpressure: hold outputs while dispatch stalls.
    i_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      set_grp(2'b11, 9, 9, 0, 0, 0, 0);
      i_valid = 1'b1;
      #1;
      chk($sformatf("bp%0d_ready", c), 128'(o_ready), 128'd0);
      @(posedge i_clk); #1;
      chk($sformatf("bp%0d_valid", c), 128'(o_valid), 128'd1);
      chk($sformatf("bp%0d_dst_hold", c), 128'(o_dst_preg), 128'({7'd39, 7'd38}));
    end
    @(negedge i_clk);
    i_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(o_ready), 128'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("bp_release_dst", 128'(o_dst_preg), 128'({7'd0, 7'd40}));
    chk("bp_release_old", 128'(o_old_dst_preg), 128'({7'd0, 7'd9}));
    chk("bp_release_src0", 128'(o_src0_preg[PW-1:0]), 128'd9);

    // Drain the free list down to a single preg (127).
    miss = 0;
    for (int g = 0; g < 43; g++) begin
      @(negedge i_clk);
      set_grp(2'b11, 10, 0, 0, 11, 0, 0);
      i_valid = 1'b1;
      #1;
      if (!o_ready) miss++;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
    end
    chk("fill_ready_misses", 128'(miss), 128'd0);
    chk("fill_last_dst", 128'(o_dst_preg), 128'({7'd126, 7'd125}));

    @(negedge i_clk);
    set_grp(2'b11, 12, 0, 0, 13, 0, 0);
    i_valid = 1'b1;
    retire(3'b001, 0, 0, 0, 7, 37, 7);
    #1;
    chk("stall_ready", 128'(o_ready), 128'd0);
    @(posedge i_clk); #1;
    retire(3'b000, 0, 0, 0, 0, 0, 0);
    chk("stall_no_accept", 128'(o_valid), 128'd0);
    @(negedge i_clk);
    #1;
    chk("stall_release_ready", 128'(o_ready), 128'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("stall_alloc", 128'(o_dst_preg), 128'({7'd127, 7'd7}));

    // Reset again, then flush with a same-cycle retire.
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    chk("rst2_valid", 128'(o_valid), 128'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    apply(mk(2'b11, 1, 0, 0, 1, 0, 0,  32, 1, 0, 0,  33, 32, 0, 0), 10);
    @(negedge i_clk);
    set_grp(2'b11, 9, 0, 0, 0, 0, 0);
    i_valid = 1'b1;
    i_flush = 1'b1;
    retire(3'b001, 0, 0, 0, 1, 32, 1);
    #1;
    chk("flush_ready", 128'(o_ready), 128'd0);
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    retire(3'b000, 0, 0, 0, 0, 0, 0);
    chk("flush_valid", 128'(o_valid), 128'd0);
    // spec[1]=32 restored; pregs 1 and 33 are the lowest free ones.
    apply(mk(2'b11, 2, 1, 0, 1, 1, 2,  1, 2, 32, 0,  33, 32, 32, 1), 11);
`ifdef RENAME_FREE_COUNT_EN
    chk("fc_after_alloc", 128'(o_free_count), 128'd94);
`endif

    // Ports 0 and 2 both retire x6; port 2 must win.
    @(negedge i_clk);
    retire(3'b101, 6, 41, 2, 6, 40, 6);
    @(posedge i_clk); #1;
    retire(3'b000, 0, 0, 0, 0, 0, 0);
`ifdef RENAME_FREE_COUNT_EN
    chk("fc_after_retire", 128'(o_free_count), 128'd96);
`endif
    @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
`ifdef RENAME_FREE_COUNT_EN
    chk("fc_after_flush", 128'(o_free_count), 128'd96);
`endif
    apply(mk(2'b11, 3, 6, 1, 0, 3, 0,  1, 3, 41, 32,  0, 0, 1, 0), 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
